// File: rtl/circ_alloc_queue.sv
// rtl/circ_alloc_queue.sv - circular allocate/complete/retire tracker
// Registered head/tail/count with per-entry valid/done; payload lives outside.
module circ_alloc_queue #(
  parameter int DEPTH    = 8,
  parameter int ALLOC_W  = 2,
  parameter int CMPL_W   = 2,
  parameter int RETIRE_W = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ALLOC_W-1:0]           alloc_req,
  output logic [ALLOC_W-1:0]           alloc_gnt,
  output logic [ALLOC_W*IDX_W-1:0]     alloc_idx,
  input  logic [CMPL_W-1:0]            cmpl_vld,
  input  logic [CMPL_W*IDX_W-1:0]      cmpl_idx,
  input  logic                         retire_en,
  output logic [RETIRE_W-1:0]          retire_vld,
  output logic [RETIRE_W*IDX_W-1:0]    retire_idx,
  input  logic                         flush,
  output logic [DEPTH-1:0]             occupied,
  output logic [IDX_W:0]               count,
  output logic                         full,
  output logic                         empty
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

  logic [IDX_W-1:0] head, tail;
  logic [DEPTH-1:0] valid, done;
  logic [DEPTH-1:0] valid_nxt, done_nxt;

  logic [ALLOC_W-1:0] req_run;
  logic [IDX_W:0]     n_req, n_gnt, n_ret, free_slots;
  logic               grant_ok;

  assign occupied   = valid;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign free_slots = DEPTH_C - count;

  // Only the unbroken run of requests from bit 0 counts.
  always_comb begin
    logic run;
    run     = 1'b1;
    n_req   = '0;
    req_run = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      run        = run & alloc_req[k];
      req_run[k] = run;
      if (run) n_req = n_req + ONE_C;
    end
  end

  assign grant_ok  = (n_req <= free_slots) && !flush;
  assign alloc_gnt = grant_ok ? req_run : '0;
  assign n_gnt     = grant_ok ? n_req : '0;

  always_comb begin
    for (int k = 0; k < ALLOC_W; k++)
      alloc_idx[k*IDX_W +: IDX_W] = tail + IDX_W'(k);
  end

  // Retire looks only at registered done, giving one cycle complete-to-retire.
  always_comb begin
    logic             ok;
    logic [IDX_W-1:0] ri;
    ok         = retire_en && !flush;
    n_ret      = '0;
    retire_vld = '0;
    retire_idx = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      ri                           = head + IDX_W'(k);
      retire_idx[k*IDX_W +: IDX_W] = ri;
      ok                           = ok & valid[ri] & done[ri];
      retire_vld[k]                = ok;
      if (ok) n_ret = n_ret + ONE_C;
    end
  end

  always_comb begin
    valid_nxt = valid;
    done_nxt  = done;
    for (int p = 0; p < CMPL_W; p++) begin
      if (cmpl_vld[p] && valid[cmpl_idx[p*IDX_W +: IDX_W]])
        done_nxt[cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
    end
    for (int k = 0; k < ALLOC_W; k++) begin
      if (alloc_gnt[k]) begin
        valid_nxt[alloc_idx[k*IDX_W +: IDX_W]] = 1'b1;
        done_nxt[alloc_idx[k*IDX_W +: IDX_W]]  = 1'b0;
      end
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (retire_vld[k]) begin
        valid_nxt[retire_idx[k*IDX_W +: IDX_W]] = 1'b0;
        done_nxt[retire_idx[k*IDX_W +: IDX_W]]  = 1'b0;
      end
    end
    if (flush) begin
      valid_nxt = '0;
      done_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      valid <= valid_nxt;
      done  <= done_nxt;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + n_ret[IDX_W-1:0];
        tail  <= tail + n_gnt[IDX_W-1:0];
        count <= count + n_gnt - n_ret;
      end
    end
  end

endmodule

// File: tb/tb_circ_alloc_queue.sv
// tb/tb_circ_alloc_queue.sv - directed self-checking bench for circ_alloc_queue
module tb_circ_alloc_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] alloc_req;
  logic [1:0] alloc_gnt;
  logic [5:0] alloc_idx;
  logic [1:0] cmpl_vld;
  logic [5:0] cmpl_idx;
  logic       retire_en;
  logic [1:0] retire_vld;
  logic [5:0] retire_idx;
  logic       flush;
  logic [7:0] occupied;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int vectors = 0;
  int errors  = 0;

  circ_alloc_queue #(.DEPTH(8), .ALLOC_W(2), .CMPL_W(2), .RETIRE_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
    .cmpl_vld(cmpl_vld), .cmpl_idx(cmpl_idx),
    .retire_en(retire_en), .retire_vld(retire_vld), .retire_idx(retire_idx),
    .flush(flush), .occupied(occupied), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; alloc_req = 2'b00; cmpl_vld = 2'b00; cmpl_idx = '0;
    retire_en = 1'b0; flush = 1'b0;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_occ", occupied, 8'h00);
    chk("rst_aidx", alloc_idx, 6'h08);
    chk("rst_rvld", retire_vld, 0);
    #1 rst_n = 1'b1;
    tick();

    // basic allocation and fill to full
    alloc_req = 2'b11; #1;
    chk("a1_gnt", alloc_gnt, 2'b11);
    chk("a1_idx", alloc_idx, 6'h08);
    tick();
    chk("a1_count", count, 2);
    chk("a1_occ", occupied, 8'h03);
    chk("a1_idx2", alloc_idx, 6'h1A);
    tick(); tick(); tick();
    chk("full_count", count, 8);
    chk("full_flag", full, 1);
    chk("full_occ", occupied, 8'hFF);
    chk("full_gnt11", alloc_gnt, 2'b00);
    alloc_req = 2'b01; #1;
    chk("full_gnt01", alloc_gnt, 2'b00);

    // flush while full with a pending completion
    alloc_req = 2'b11; flush = 1'b1; cmpl_vld = 2'b01; cmpl_idx = 6'd0; retire_en = 1'b1; #1;
    chk("fl1_gnt", alloc_gnt, 2'b00);
    chk("fl1_rvld", retire_vld, 2'b00);
    tick();
    flush = 1'b0; cmpl_vld = 2'b00; retire_en = 1'b0; #1;
    chk("fl1_count", count, 0);
    chk("fl1_empty", empty, 1);
    chk("fl1_occ", occupied, 8'h00);
    chk("fl1_tail", alloc_idx, 6'h08);
    chk("fl1_head", retire_idx, 6'h08);

    // out-of-order completion: allocate 0..3
    tick(); tick();
    alloc_req = 2'b00; #1;
    chk("ooo_count", count, 4);
    cmpl_vld = 2'b01; cmpl_idx = 6'd1; retire_en = 1'b1; #1;
    chk("ooo_r0", retire_vld, 2'b00);
    tick();
    cmpl_idx = 6'd0; #1;
    chk("ooo_r1", retire_vld, 2'b00);
    tick();
    cmpl_vld = 2'b00; #1;
    chk("ooo_r2", retire_vld, 2'b11);
    chk("ooo_ridx", retire_idx, 6'h08);
    tick();
    chk("ooo_count2", count, 2);
    chk("ooo_occ2", occupied, 8'h0C);
    chk("ooo_hold", retire_vld, 2'b00);
    cmpl_vld = 2'b11; cmpl_idx = {3'd3, 3'd2}; #1;
    chk("ooo_r3", retire_vld, 2'b00);
    tick();
    cmpl_vld = 2'b00; #1;
    chk("ooo_r4", retire_vld, 2'b11);
    chk("ooo_ridx2", retire_idx, 6'h1A);
    tick();
    chk("ooo_empty", empty, 1);

    // move head/tail to 6
    alloc_req = 2'b11; tick();
    alloc_req = 2'b00; cmpl_vld = 2'b11; cmpl_idx = {3'd5, 3'd4}; tick();
    cmpl_vld = 2'b00; tick();
    chk("pre_wrap_count", count, 0);
    chk("pre_wrap_tail", alloc_idx, {3'd7, 3'd6});

    // wrap-around
    alloc_req = 2'b11; #1;
    chk("wr_gnt1", alloc_gnt, 2'b11);
    chk("wr_idx1", alloc_idx, {3'd7, 3'd6});
    tick();
    chk("wr_gnt2", alloc_gnt, 2'b11);
    chk("wr_idx2", alloc_idx, {3'd1, 3'd0});
    tick();
    alloc_req = 2'b00; #1;
    chk("wr_count", count, 4);
    chk("wr_occ", occupied, 8'hC3);
    cmpl_vld = 2'b11; cmpl_idx = {3'd7, 3'd6}; #1;
    chk("wr_r0", retire_vld, 2'b00);
    tick();
    cmpl_idx = {3'd1, 3'd0}; #1;
    chk("wr_r1", retire_vld, 2'b11);
    chk("wr_ridx1", retire_idx, {3'd7, 3'd6});
    tick();
    cmpl_vld = 2'b00; #1;
    chk("wr_count2", count, 2);
    chk("wr_r2", retire_vld, 2'b11);
    chk("wr_ridx2", retire_idx, {3'd1, 3'd0});
    tick();
    chk("wr_count3", count, 0);

    // boundaries: fill to 7 from head=tail=2
    retire_en = 1'b0; alloc_req = 2'b11; tick();
    cmpl_vld = 2'b01; cmpl_idx = 6'd2; tick();
    cmpl_vld = 2'b00; tick();
    alloc_req = 2'b01; tick();
    alloc_req = 2'b11; retire_en = 1'b1; #1;
    chk("b_count7", count, 7);
    chk("b_occ", occupied, 8'hFD);
    chk("b_r1", retire_vld, 2'b01);
    chk("b_gnt0", alloc_gnt, 2'b00);
    tick();
    chk("b_count6", count, 6);
    alloc_req = 2'b01; cmpl_vld = 2'b01; cmpl_idx = 6'd3; #1;
    chk("b_r0", retire_vld, 2'b00);
    chk("b_gnt_free2", alloc_gnt, 2'b01);
    tick();
    cmpl_vld = 2'b00; #1;
    chk("b_count7b", count, 7);
    chk("b_r1b", retire_vld, 2'b01);
    chk("b_gnt01", alloc_gnt, 2'b01);
    tick();
    chk("b_stay7", count, 7);
    alloc_req = 2'b10; retire_en = 1'b0; #1;
    chk("b_gnt10", alloc_gnt, 2'b00);
    tick();
    chk("b_count10", count, 7);

    // flush with pending completion
    alloc_req = 2'b11; flush = 1'b1; cmpl_vld = 2'b01; cmpl_idx = 6'd5; retire_en = 1'b1; #1;
    chk("fl2_gnt", alloc_gnt, 2'b00);
    chk("fl2_rvld", retire_vld, 2'b00);
    tick();
    flush = 1'b0; alloc_req = 2'b00; cmpl_vld = 2'b00; retire_en = 1'b0; #1;
    chk("fl2_count", count, 0);
    chk("fl2_empty", empty, 1);
    chk("fl2_occ", occupied, 8'h00);
    chk("fl2_head", retire_idx, 6'h08);
    chk("fl2_tail", alloc_idx, 6'h08);

    // async reset between edges
    alloc_req = 2'b11; tick();
    alloc_req = 2'b00; #1;
    chk("ar_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count0", count, 0);
    chk("ar_occ0", occupied, 8'h00);
    chk("ar_empty", empty, 1);
    chk("ar_tail", alloc_idx, 6'h08);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_post", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/circ_alloc_queue.md
Name: circ_alloc_queue

Overview:
- Parametrised circular allocation queue.
- Successor to the single-slot write-position detector. It holds registered head/tail/count state instead of deriving the tail from a valid vector.
- Supports multiple allocations per cycle, out-of-order completion, in-order multi-entry retire from head, and flush.
- Sits in the backend as the allocate/complete/retire tracker for ROB-like and LSQ-like structures; data payload storage stays outside this block.

Parameters:
- DEPTH, default 8: number of entries; power of two, at least 4.
- ALLOC_W, default 2: maximum allocations per cycle; at most DEPTH.
- CMPL_W, default 2: number of completion ports.
- RETIRE_W, default 2: maximum retires per cycle; at most DEPTH.
- IDX_W, default $clog2(DEPTH): entry index width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- alloc_req  in  ALLOC_W  thermometer allocation request; only the contiguous run of 1s starting at bit 0 counts.
- alloc_gnt  out  ALLOC_W  combinational grant; all-or-nothing.
- alloc_idx  out  ALLOC_W*IDX_W  slot k index = (tail+k) mod DEPTH; valid regardless of grant.
- cmpl_vld  in  CMPL_W  completion strobe per port.
- cmpl_idx  in  CMPL_W*IDX_W  entry index per completion port.
- retire_en  in  1  permits retire this cycle.
- retire_vld  out  RETIRE_W  thermometer of entries retiring this cycle.
- retire_idx  out  RETIRE_W*IDX_W  slot k index = (head+k) mod DEPTH.
- flush  in  1  synchronous clear of all entries.
- occupied  out  DEPTH  registered valid vector.
- count  out  IDX_W+1  registered occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- State: head, tail (IDX_W, wrap mod DEPTH); count (IDX_W+1); valid[DEPTH]; done[DEPTH].
- Reset (async assert): all state 0.
  - empty=1, full=0, count=0, occupied=0.
  - alloc_idx slot k = k.
  - retire_vld=0; alloc_gnt follows alloc_req.
- Allocation:
  - n_req = length of the leading-1 run in alloc_req.
  - alloc_gnt = that run if n_req <= DEPTH-count (registered count), else 0.
  - Same-cycle retire does not free space for same-cycle alloc.
  - Granted slots set valid=1, done=0 at the edge; tail += n_gnt.
- Completion:
  - cmpl_vld[p] with valid[cmpl_idx]=1 sets done at the edge.
  - Completion to an invalid entry is ignored, including an entry allocated in the same cycle.
  - Duplicate indices across ports are harmless.
- Retire (combinational from registered state):
  - retire_vld[k]=1 iff retire_en, !flush, and every entry head..head+k has valid & done.
  - retire_vld is thermometer and is capped at RETIRE_W.
  - At the edge, retired entries clear valid and done; head += n_ret.
  - A completion arriving in the cycle its entry is at head retires no earlier than the next cycle (1-cycle complete-to-retire latency).
- count_next = count + n_gnt - n_ret. Retire and alloc on the same cycle are both applied; count never exceeds DEPTH and never underflows.
- Wrap-around: all index arithmetic is mod DEPTH; full is distinguished from empty by count, never by head==tail.
- Flush:
  - alloc_gnt and retire_vld are forced 0 combinationally.
  - At the edge: head=tail=count=0 and valid=done=0.
  - Flush overrides completion and allocation in the same cycle.
- Reset asserted mid-operation clears state immediately and asynchronously. Outputs are valid from the first edge after deassertion.
- No X on any output after reset; alloc_idx/retire_idx are don't-care-free (always computed).

Test Plan:
- Reset, then alloc_req=2'b11 -> alloc_gnt=2'b11, alloc_idx={1,0}; next cycle count=2, occupied=8'h03.
- Four cycles of alloc_req=2'b11 from reset -> count=8, full=1, occupied=8'hFF; fifth request -> alloc_gnt=0.
- Out-of-order completion:
  - Allocate 0..3; cmpl idx 1, then idx 0 one cycle later, retire_en=1.
  - Retire_vld=2'b11 (idx 0,1) exactly one cycle after the idx 0 completion.
  - Entries 2/3 do not retire until done.
- Wrap-around: with head=tail=6 and count=0, alloc 2'b11 twice -> indices 6,7 then 0,1; complete all, retire_en=1 -> retire 6,7 then 0,1, and count returns to 0.
- Boundaries:
  - count=7, alloc_req=2'b11 with head retiring -> alloc_gnt=0, count=6.
  - alloc_req=2'b01 with a 1-entry retire -> count stays 7.
  - alloc_req=2'b10 -> treated as no request.
- Flush/reset:
  - Flush with alloc_req=2'b11 and pending completions -> alloc_gnt=0 that cycle; next cycle count=0, head=tail=0, empty=1.
  - Async rst_n pulse between edges -> outputs cleared immediately.
